// File: rtl/axi_rdata_return.sv
// rtl/axi_rdata_return.sv - AXI read-data return stage: per-beat peripheral read, response FIFO, R channel
`ifndef SLAVE_ID_BITS
`define SLAVE_ID_BITS 4
`endif

module axi_rdata_return #(
  parameter int masters = 4,
  parameter int width   = 22,
  parameter int p_size  = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                      CLK,
  input  logic                      RESETN,
  input  logic [masters-1:0]        I_MASTER,
  input  logic [`SLAVE_ID_BITS-1:0] I_ID,
  input  logic [width-1:0]          I_ADDR,
  input  logic                      I_LAST,
  input  logic                      I_VALID,
  output logic                      I_READY,
  output logic [width-1:0]          P_ADDR,
  output logic                      P_RD,
  input  logic [(8<<p_size)-1:0]    P_RDATA,
  input  logic                      P_DONE,
  output logic [masters-1:0]        R_MASTER,
  output logic [`SLAVE_ID_BITS-1:0] R_ID,
  output logic [(8<<p_size)-1:0]    R_DATA,
  output logic [1:0]                R_RESP,
  output logic                      R_LAST,
  output logic                      R_VALID,
  input  logic                      R_READY,
  output logic [7:0]                ERR_CNT
);

  localparam int DW  = 8 << p_size;
  localparam int IDW = `SLAVE_ID_BITS;
  localparam int AW  = $clog2(DEPTH);

  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [7:0]  TMO_C   = TIMEOUT[7:0];

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]         state;
  logic [7:0]         timer;
  logic [masters-1:0] tag_master;
  logic [IDW-1:0]     tag_id;
  logic               tag_last;

  logic [masters-1:0] mem_master [DEPTH];
  logic [IDW-1:0]     mem_id     [DEPTH];
  logic               mem_last   [DEPTH];
  logic [DW-1:0]      mem_data   [DEPTH];
  logic [1:0]         mem_resp   [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_count;

  logic accept;
  logic done_hit;
  logic tmo_hit;
  logic push;
  logic pop;

  // Completion wins over a timeout landing in the same cycle
  assign done_hit = (state == ST_WAIT) && P_DONE;
  assign tmo_hit  = (state == ST_WAIT) && !P_DONE && (timer == TMO_C);
  assign push     = done_hit || tmo_hit;

  // Accept only with no read in flight and room in the FIFO, so a push never overflows
  assign I_READY = RESETN && (state == ST_IDLE) && (fifo_count < DEPTH_C);
  assign accept  = I_VALID && I_READY;

  assign R_VALID = (fifo_count != '0);
  assign pop     = R_VALID && R_READY;

  // Head of FIFO drives the R channel; outputs read as zero while empty
  assign R_MASTER = R_VALID ? mem_master[rd_ptr] : '0;
  assign R_ID     = R_VALID ? mem_id[rd_ptr]     : '0;
  assign R_LAST   = R_VALID ? mem_last[rd_ptr]   : 1'b0;
  assign R_DATA   = R_VALID ? mem_data[rd_ptr]   : '0;
  assign R_RESP   = R_VALID ? mem_resp[rd_ptr]   : 2'b00;

  // Read sequencer: latch beat, strobe peripheral once, wait for done or timeout
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state      <= ST_IDLE;
      timer      <= 8'd0;
      P_ADDR     <= '0;
      P_RD       <= 1'b0;
      tag_master <= '0;
      tag_id     <= '0;
      tag_last   <= 1'b0;
      ERR_CNT    <= 8'd0;
    end else begin
      P_RD <= 1'b0;
      if (state == ST_IDLE) begin
        if (accept) begin
          tag_master <= I_MASTER;
          tag_id     <= I_ID;
          tag_last   <= I_LAST;
          P_ADDR     <= I_ADDR;
          P_RD       <= 1'b1;
          timer      <= 8'd1;
          state      <= ST_WAIT;
        end
      end else begin
        if (push) begin
          timer <= 8'd0;
          state <= ST_IDLE;
          if (tmo_hit && (ERR_CNT != 8'hFF)) begin
            ERR_CNT <= ERR_CNT + 8'd1;
          end
        end else begin
          timer <= timer + 8'd1;
        end
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + (AW+1)'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - (AW+1)'(1);
      end
    end
  end

  // FIFO storage; contents are only observed through the occupancy-gated outputs
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_master[wr_ptr] <= tag_master;
      mem_id[wr_ptr]     <= tag_id;
      mem_last[wr_ptr]   <= tag_last;
      mem_data[wr_ptr]   <= done_hit ? P_RDATA : '0;
      mem_resp[wr_ptr]   <= done_hit ? 2'b00 : 2'b10;
    end
  end

endmodule

// File: tb/tb_axi_rdata_return.sv
// tb/tb_axi_rdata_return.sv - self-checking bench for axi_rdata_return
`ifndef SLAVE_ID_BITS
`define SLAVE_ID_BITS 4
`endif

module tb_axi_rdata_return;

  localparam int TIMEOUT = 255;

  logic         CLK = 1'b0;
  logic         RESETN;
  logic [3:0]   I_MASTER;
  logic [`SLAVE_ID_BITS-1:0] I_ID;
  logic [21:0]  I_ADDR;
  logic         I_LAST;
  logic         I_VALID;
  logic         I_READY;
  logic [21:0]  P_ADDR;
  logic         P_RD;
  logic [127:0] P_RDATA;
  logic         P_DONE;
  logic [3:0]   R_MASTER;
  logic [`SLAVE_ID_BITS-1:0] R_ID;
  logic [127:0] R_DATA;
  logic [1:0]   R_RESP;
  logic         R_LAST;
  logic         R_VALID;
  logic         R_READY;
  logic [7:0]   ERR_CNT;

  axi_rdata_return #(.masters(4), .width(22), .p_size(4), .DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .I_MASTER(I_MASTER), .I_ID(I_ID), .I_ADDR(I_ADDR), .I_LAST(I_LAST),
    .I_VALID(I_VALID), .I_READY(I_READY),
    .P_ADDR(P_ADDR), .P_RD(P_RD), .P_RDATA(P_RDATA), .P_DONE(P_DONE),
    .R_MASTER(R_MASTER), .R_ID(R_ID), .R_DATA(R_DATA), .R_RESP(R_RESP),
    .R_LAST(R_LAST), .R_VALID(R_VALID), .R_READY(R_READY), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]   master;
    logic [3:0]   id;
    logic [21:0]  addr;
    logic         last;
    logic [127:0] data;
    int           lat;
    logic [1:0]   exp_resp;
    logic [127:0] exp_data;
    logic [7:0]   exp_err;
  } vec_t;

  typedef struct {
    logic [3:0]   master;
    logic [3:0]   id;
    logic         last;
    logic [1:0]   resp;
    logic [127:0] data;
  } ent_t;

  int   checks = 0;
  int   errors = 0;
  int   prd_cnt = 0;
  bit   mon_en = 1'b0;
  ent_t q[$];
  vec_t tbl[5];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  always @(posedge CLK) begin
    if (RESETN && P_RD) prd_cnt++;
  end

  // Issue one beat and play the peripheral: P_DONE in WAIT cycle lat+1, never if lat >= TIMEOUT
  task automatic run_beat(input logic [3:0] m, input logic [3:0] id, input logic [21:0] a,
                          input logic l, input logic [127:0] d, input int lat);
    int   n;
    int   p0;
    ent_t e;
    I_MASTER = m; I_ID = id; I_ADDR = a; I_LAST = l; I_VALID = 1'b1;
    n = 0;
    while (!I_READY && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) begin
      errors++; checks++;
      $display("FAIL accept_wait: I_READY never rose");
    end
    p0 = prd_cnt;
    tick();
    I_VALID = 1'b0;
    chk("p_rd_first_wait", P_RD, 1'b1);
    chk("p_addr", P_ADDR, a);
    for (int k = 1; k <= TIMEOUT; k++) begin
      if (k == lat + 1) begin
        P_DONE = 1'b1;
        P_RDATA = d;
      end
      tick();
      P_DONE = 1'b0;
      P_RDATA = '0;
      if (k == lat + 1) break;
    end
    chk("p_rd_pulses", prd_cnt - p0, 1);
    e.master = m; e.id = id; e.last = l;
    e.resp = (lat < TIMEOUT) ? 2'b00 : 2'b10;
    e.data = (lat < TIMEOUT) ? d : 128'h0;
    q.push_back(e);
  endtask

  // Scoreboard for the random phase: the FIFO head must match the oldest unreturned beat
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("r_valid_vs_model", R_VALID, q.size() != 0);
      if (R_VALID && q.size() != 0) begin
        chk("r_beat_vs_model", {R_MASTER, R_ID, R_LAST, R_RESP, R_DATA},
            {q[0].master, q[0].id, q[0].last, q[0].resp, q[0].data});
      end
      R_READY = 1'($urandom_range(0, 1));
      if (R_VALID && R_READY && q.size() != 0) void'(q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RESETN = 1'b0; I_MASTER = '0; I_ID = '0; I_ADDR = '0; I_LAST = 1'b0; I_VALID = 1'b0;
    P_RDATA = '0; P_DONE = 1'b0; R_READY = 1'b0;

    tbl[0] = '{4'b0010, 4'd3,  22'h000100, 1'b1, {16{8'hA5}},       0,   2'b00, {16{8'hA5}},       8'd0};
    tbl[1] = '{4'b1000, 4'd12, 22'h3FFFF0, 1'b0, {4{32'h01234567}}, 3,   2'b00, {4{32'h01234567}}, 8'd0};
    tbl[2] = '{4'b0001, 4'd5,  22'h000200, 1'b1, {4{32'hDEADBEEF}}, 254, 2'b00, {4{32'hDEADBEEF}}, 8'd0};
    tbl[3] = '{4'b0100, 4'd7,  22'h000300, 1'b1, {16{8'h5A}},       255, 2'b10, 128'h0,            8'd1};
    tbl[4] = '{4'b0010, 4'd1,  22'h1ABCDE, 1'b0, {8{16'hC3C3}},     1,   2'b00, {8{16'hC3C3}},     8'd1};

    // Reset state
    #2;
    chk("rst_i_ready", I_READY, 1'b0);
    chk("rst_r_outputs", {R_VALID, R_MASTER, R_ID, R_LAST, R_RESP, R_DATA}, '0);
    chk("rst_err_cnt", ERR_CNT, 8'd0);
    chk("rst_p_rd_addr", {P_RD, P_ADDR}, '0);
    tick(); tick();
    RESETN = 1'b1;
    tick();
    chk("post_rst_i_ready", I_READY, 1'b1);
    repeat (3) tick();
    chk("idle_no_p_rd", prd_cnt, 0);

    // Table-driven single beats, including timeout and coincident-completion cases
    for (int i = 0; i < 5; i++) begin
      q.delete();
      R_READY = 1'b0;
      run_beat(tbl[i].master, tbl[i].id, tbl[i].addr, tbl[i].last, tbl[i].data, tbl[i].lat);
      chk("tbl_r_valid", R_VALID, 1'b1);
      chk("tbl_r_tag", {R_MASTER, R_ID, R_LAST}, {tbl[i].master, tbl[i].id, tbl[i].last});
      chk("tbl_r_resp", R_RESP, tbl[i].exp_resp);
      chk("tbl_r_data", R_DATA, tbl[i].exp_data);
      chk("tbl_err_cnt", ERR_CNT, tbl[i].exp_err);
      R_READY = 1'b1;
      tick();
      R_READY = 1'b0;
      chk("tbl_popped", R_VALID, 1'b0);
      if (tbl[i].lat >= TIMEOUT) begin
        repeat (10) tick();
        P_DONE = 1'b1; P_RDATA = {16{8'hEE}};
        tick();
        P_DONE = 1'b0; P_RDATA = '0;
        repeat (3) tick();
        chk("late_done_no_beat", R_VALID, 1'b0);
        chk("late_done_err_cnt", ERR_CNT, 8'd1);
        chk("late_done_i_ready", I_READY, 1'b1);
      end
    end

    // Four-beat burst into a stalled R channel, then drain
    q.delete();
    R_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_beat(4'b0001 << i, 4'(i + 8), 22'(32'h400 + i * 16), i == 3,
               {$urandom, $urandom, $urandom, $urandom}, 0);
    end
    chk("full_i_ready", I_READY, 1'b0);
    repeat (3) tick();
    chk("stall_hold_head", {R_VALID, R_ID, R_DATA}, {1'b1, q[0].id, q[0].data});
    for (int i = 0; i < 4; i++) begin
      chk("drain_beat", {R_VALID, R_MASTER, R_ID, R_LAST, R_DATA},
          {1'b1, q[i].master, q[i].id, q[i].last, q[i].data});
      R_READY = 1'b1;
      tick();
    end
    R_READY = 1'b0;
    chk("drain_empty", R_VALID, 1'b0);

    // Asynchronous reset with two buffered entries and a read in flight
    q.delete();
    run_beat(4'b0001, 4'd2, 22'h000010, 1'b0, {16{8'h11}}, 0);
    run_beat(4'b0010, 4'd3, 22'h000020, 1'b1, {16{8'h22}}, 0);
    I_MASTER = 4'b0100; I_ID = 4'd4; I_ADDR = 22'h000030; I_LAST = 1'b0; I_VALID = 1'b1;
    tick();
    I_VALID = 1'b0;
    chk("pre_rst_state", {R_VALID, P_RD}, 2'b11);
    #2;
    RESETN = 1'b0;
    #1;
    chk("async_rst_drop", {R_VALID, P_RD, I_READY}, 3'b000);
    tick();
    RESETN = 1'b1;
    tick();
    chk("post_rst_empty", {R_VALID, ERR_CNT}, 9'd0);
    q.delete();
    run_beat(4'b1000, 4'd9, 22'h0000F0, 1'b1, {16{8'h77}}, 2);
    chk("post_rst_beat", {R_VALID, R_MASTER, R_ID, R_LAST, R_RESP, R_DATA},
        {1'b1, 4'b1000, 4'd9, 1'b1, 2'b00, {16{8'h77}}});
    R_READY = 1'b1;
    tick();
    R_READY = 1'b0;

    // Random beats against the scoreboard with random back-pressure
    q.delete();
    @(negedge CLK);
    mon_en = 1'b1;
    tick();
    for (int i = 0; i < 150; i++) begin
      run_beat(4'b0001 << $urandom_range(0, 3), 4'($urandom), 22'($urandom), 1'($urandom),
               {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 4));
    end
    for (int n = 0; n < 200 && q.size() != 0; n++) tick();
    chk("random_drained", q.size(), 0);
    @(negedge CLK);
    mon_en = 1'b0;
    R_READY = 1'b0;
    #1;
    chk("random_end_state", {R_VALID, ERR_CNT}, 9'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
